// File: rtl/ham_pkg.sv
// Shared Hamming(7,4) definitions: codeword layout, stored word format and
// the single-error-correcting decode used by both receive and encoder benches.
package ham_pkg;

    localparam int CW_W       = 7;
    localparam int DATA_W     = 4;
    localparam int HAM_WORD_W = DATA_W + 3 + 1;

    localparam int P1 = 0;
    localparam int P2 = 1;
    localparam int D0 = 2;
    localparam int P4 = 3;
    localparam int D1 = 4;
    localparam int D2 = 5;
    localparam int D3 = 6;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [2:0]        syndrome;
        logic              corrected;
    } ham_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } rx_state_t;

    function automatic ham_word_t ham_correct(input logic [CW_W-1:0] cw);
        ham_word_t w;
        logic [2:0] syn;
        logic [DATA_W-1:0] data;
        syn[0] = cw[P1] ^ cw[D0] ^ cw[D1] ^ cw[D3];
        syn[1] = cw[P2] ^ cw[D0] ^ cw[D2] ^ cw[D3];
        syn[2] = cw[P4] ^ cw[D1] ^ cw[D2] ^ cw[D3];
        data   = {cw[D3], cw[D2], cw[D1], cw[D0]};
        // Syndromes 1, 2 and 4 point at parity bits, so the data is left alone.
        case (syn)
            3'd3:    data[0] = ~data[0];
            3'd5:    data[1] = ~data[1];
            3'd6:    data[2] = ~data[2];
            3'd7:    data[3] = ~data[3];
            default: data    = data;
        endcase
        w.data      = data;
        w.syndrome  = syn;
        w.corrected = (syn != 3'd0);
        return w;
    endfunction

endpackage

// File: rtl/ham_fifo.sv
// First-word-fall-through FIFO of decoded Hamming words; the head entry is
// presented combinationally and a push into a full FIFO succeeds only alongside a pop.
module ham_fifo
    import ham_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [HAM_WORD_W-1:0] push_word,
    input  logic                  pop_ready,
    output logic                  valid,
    output logic [HAM_WORD_W-1:0] head,
    output logic                  push_ok
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [HAM_WORD_W-1:0] mem_q [DEPTH];
    logic                  empty;
    logic                  full;
    logic                  pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = !empty && pop_ready;
    assign push_ok = push && (!full || pop);
    assign valid   = !empty;
    assign head    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_word;
        end
    end

endmodule

// File: rtl/ham_serial_rx.sv
// Serial Hamming(7,4) receiver: frames qualified bits into codewords, corrects
// single-bit errors, buffers results and keeps saturating link statistics.
module ham_serial_rx
    import ham_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_bit_valid,
    input  logic             rx_bit,
    input  logic             rx_sof,
    input  logic             o_ready,
    output logic             o_valid,
    output logic [3:0]       o_data,
    output logic [2:0]       o_syndrome,
    output logic             o_corrected,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] abort_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int N_CNT    = 3;
    localparam int IDX_CORR = 0;
    localparam int IDX_ABRT = 1;
    localparam int IDX_DROP = 2;

    rx_state_t       state_q, state_d;
    logic [2:0]      count_q, count_d;
    logic [CW_W-1:0] cw_q, cw_d;

    logic            push;
    logic            push_ok;
    logic            abort;
    ham_word_t       push_word;
    ham_word_t       head_word;

    logic [N_CNT-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_q [N_CNT];
    logic [CNT_W-1:0] cnt_d [N_CNT];

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        cw_d      = cw_q;
        push      = 1'b0;
        abort     = 1'b0;
        push_word = ham_correct(cw_q);
        case (state_q)
            // CHECK decodes the finished word while accepting input exactly like IDLE.
            IDLE, CHECK: begin
                push    = (state_q == CHECK);
                state_d = IDLE;
                if (rx_bit_valid && rx_sof) begin
                    cw_d[0] = rx_bit;
                    count_d = 3'd1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (rx_bit_valid) begin
                    if (rx_sof) begin
                        abort   = 1'b1;
                        cw_d[0] = rx_bit;
                        count_d = 3'd1;
                    end else begin
                        cw_d[count_q] = rx_bit;
                        count_d       = count_q + 3'd1;
                        if (count_q == 3'd6) begin
                            count_d = 3'd0;
                            state_d = CHECK;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                count_d = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= 3'd0;
            cw_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            cw_q    <= cw_d;
        end
    end

    ham_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_word(push_word),
        .pop_ready(o_ready),
        .valid    (o_valid),
        .head     (head_word),
        .push_ok  (push_ok)
    );

    assign o_data      = head_word.data;
    assign o_syndrome  = head_word.syndrome;
    assign o_corrected = head_word.corrected;

    assign cnt_inc[IDX_CORR] = push && push_word.corrected;
    assign cnt_inc[IDX_ABRT] = abort;
    assign cnt_inc[IDX_DROP] = push && !push_ok;

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_comb begin
        for (int i = 0; i < N_CNT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr_stats) begin
                cnt_d[i] = '0;
            end else if (cnt_inc[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CNT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign corr_cnt  = cnt_q[IDX_CORR];
    assign abort_cnt = cnt_q[IDX_ABRT];
    assign drop_cnt  = cnt_q[IDX_DROP];

endmodule

// File: tb/tb_ham_serial_rx.sv
// Bench for ham_serial_rx: directed scenarios plus randomized framing, checked
// every cycle against a positional-syndrome model with a queue-based FIFO.
module tb_ham_serial_rx;

    localparam int DEPTH = 4;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             rx_bit_valid = 1'b0;
    logic             rx_bit = 1'b0;
    logic             rx_sof = 1'b0;
    logic             o_ready = 1'b0;
    logic             clr_stats = 1'b0;
    logic             o_valid;
    logic [3:0]       o_data;
    logic [2:0]       o_syndrome;
    logic             o_corrected;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] abort_cnt;
    logic [CNT_W-1:0] drop_cnt;

    int checks = 0;
    int errors = 0;
    bit rnd_mode = 1'b0;

    ham_serial_rx #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_bit_valid(rx_bit_valid),
        .rx_bit      (rx_bit),
        .rx_sof      (rx_sof),
        .o_ready     (o_ready),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .o_syndrome  (o_syndrome),
        .o_corrected (o_corrected),
        .clr_stats   (clr_stats),
        .corr_cnt    (corr_cnt),
        .abort_cnt   (abort_cnt),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endfunction

    // Syndrome = XOR of 1-based positions of all set bits.
    function automatic bit [7:0] ref_decode(input bit [6:0] cw_in);
        bit [6:0] cw;
        int s;
        cw = cw_in;
        s = 0;
        for (int i = 0; i < 7; i++) if (cw[i]) s ^= (i + 1);
        if (s != 0) cw[s-1] = ~cw[s-1];
        return {cw[6], cw[5], cw[4], cw[2], s[2:0], (s != 0)};
    endfunction

    function automatic bit [6:0] ref_encode(input bit [3:0] d);
        bit [6:0] cw;
        int s;
        cw = '0;
        cw[2] = d[0]; cw[4] = d[1]; cw[5] = d[2]; cw[6] = d[3];
        s = 0;
        for (int i = 0; i < 7; i++) if (cw[i]) s ^= (i + 1);
        cw[0] = s[0]; cw[1] = s[1]; cw[3] = s[2];
        return cw;
    endfunction

    // ---------------- reference model ----------------
    bit [7:0] mq[$];
    bit [6:0] m_bits;
    int       m_nbits = 0;
    bit       m_pend = 1'b0;
    bit [7:0] m_pend_w;
    int       m_corr = 0, m_abort = 0, m_drop = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_nbits = 0;
            m_pend  = 1'b0;
            m_corr  = 0;
            m_abort = 0;
            m_drop  = 0;
        end else begin
            if (mq.size() > 0 && o_ready) void'(mq.pop_front());
            if (m_pend) begin
                if (m_pend_w[0] && m_corr < CMAX) m_corr++;
                if (mq.size() < DEPTH) mq.push_back(m_pend_w);
                else if (m_drop < CMAX) m_drop++;
                m_pend = 1'b0;
            end
            if (rx_bit_valid) begin
                if (rx_sof) begin
                    if (m_nbits > 0 && m_abort < CMAX) m_abort++;
                    m_bits[0] = rx_bit;
                    m_nbits   = 1;
                end else if (m_nbits > 0) begin
                    m_bits[m_nbits] = rx_bit;
                    m_nbits++;
                    if (m_nbits == 7) begin
                        m_pend   = 1'b1;
                        m_pend_w = ref_decode(m_bits);
                        m_nbits  = 0;
                    end
                end
            end
            if (clr_stats) begin
                m_corr  = 0;
                m_abort = 0;
                m_drop  = 0;
            end
        end
    end

    always @(negedge clk) begin
        bit [7:0] e;
        e = (mq.size() > 0) ? mq[0] : 8'h00;
        chk("o_valid", int'(o_valid), int'(mq.size() > 0));
        chk("o_data", int'(o_data), int'(e[7:4]));
        chk("o_syndrome", int'(o_syndrome), int'(e[3:1]));
        chk("o_corrected", int'(o_corrected), int'(e[0]));
        chk("corr_cnt", int'(corr_cnt), m_corr);
        chk("abort_cnt", int'(abort_cnt), m_abort);
        chk("drop_cnt", int'(drop_cnt), m_drop);
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit v, input bit b, input bit s);
        @(posedge clk);
        #2;
        rx_bit_valid = v;
        rx_bit       = b;
        rx_sof       = s;
        clr_stats    = 1'b0;
        if (rnd_mode) begin
            o_ready   = ($urandom_range(0, 3) != 0);
            clr_stats = ($urandom_range(0, 99) == 0);
        end
    endtask

    task automatic send_frame(input bit [6:0] cw);
        for (int i = 0; i < 7; i++) cyc(1'b1, cw[i], i == 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_clr();
        cyc(1'b0, 1'b0, 1'b0);
        clr_stats = 1'b1;
    endtask

    task automatic pop_one();
        o_ready = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        o_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("reset o_valid", int'(o_valid), 0);
        chk("reset o_data", int'(o_data), 0);
        chk("reset corr_cnt", int'(corr_cnt), 0);

        // Clean frame and output latency
        chk("encode B", int'(ref_encode(4'hB)), 7'b1010101);
        send_frame(7'b1010101);
        cyc(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("latency pre", int'(o_valid), 0);
        @(negedge clk);
        chk("latency valid", int'(o_valid), 1);
        chk("clean data", int'(o_data), 4'b1011);
        chk("clean syndrome", int'(o_syndrome), 0);
        chk("clean corrected", int'(o_corrected), 0);
        pop_one();

        // Single data error on c4
        do_clr();
        send_frame(7'b1000101);
        idle(2);
        @(negedge clk);
        chk("c4 data", int'(o_data), 4'b1011);
        chk("c4 syndrome", int'(o_syndrome), 3'b101);
        chk("c4 corrected", int'(o_corrected), 1);
        chk("c4 corr_cnt", int'(corr_cnt), 1);
        pop_one();

        // Parity error then back-to-back frame
        do_clr();
        send_frame(7'b1110111);
        send_frame(7'b0000000);
        idle(2);
        @(negedge clk);
        chk("b2b first data", int'(o_data), 4'hF);
        chk("b2b first syndrome", int'(o_syndrome), 4);
        chk("b2b first corrected", int'(o_corrected), 1);
        pop_one();
        @(negedge clk);
        chk("b2b second valid", int'(o_valid), 1);
        chk("b2b second data", int'(o_data), 4'h0);
        chk("b2b second syndrome", int'(o_syndrome), 0);
        pop_one();

        // Abort after three bits
        do_clr();
        chk("encode 5", int'(ref_encode(4'h5)), 7'b0101101);
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        send_frame(ref_encode(4'h5));
        idle(2);
        @(negedge clk);
        chk("abort abort_cnt", int'(abort_cnt), 1);
        chk("abort data", int'(o_data), 4'h5);
        pop_one();
        @(negedge clk);
        chk("abort single entry", int'(o_valid), 0);

        // Overflow: DEPTH+2 frames while stalled
        do_clr();
        for (int k = 1; k <= DEPTH + 2; k++) send_frame(ref_encode(4'(k)));
        idle(2);
        @(negedge clk);
        chk("overflow drop_cnt", int'(drop_cnt), 2);
        chk("overflow head", int'(o_data), 1);
        o_ready = 1'b1;
        idle(DEPTH + 2);
        o_ready = 1'b0;
        @(negedge clk);
        chk("overflow drained", int'(o_valid), 0);

        // Counter saturation and clear
        do_clr();
        o_ready = 1'b1;
        for (int k = 0; k < 5; k++) send_frame(ref_encode(4'(k + 3)) ^ 7'(1 << k));
        idle(2);
        @(negedge clk);
        chk("sat corr_cnt", int'(corr_cnt), CMAX);
        do_clr();
        cyc(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("clr corr_cnt", int'(corr_cnt), 0);

        // Randomized framing, gaps, errors, aborts, backpressure, clears
        rnd_mode = 1'b1;
        for (int f = 0; f < 150; f++) begin
            bit [6:0] cw;
            int sel;
            cw  = ref_encode(4'($urandom_range(0, 15)));
            sel = $urandom_range(0, 9);
            if (sel >= 6) cw[$urandom_range(0, 6)] ^= 1'b1;
            if (sel == 9) cw[$urandom_range(0, 6)] ^= 1'b1;
            if ($urandom_range(0, 14) == 0) begin
                int n;
                n = $urandom_range(1, 6);
                for (int i = 0; i < n; i++) cyc(1'b1, 1'($urandom_range(0, 1)), i == 0);
            end
            if ($urandom_range(0, 7) == 0) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            for (int i = 0; i < 7; i++) begin
                while ($urandom_range(0, 3) == 0)
                    cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                cyc(1'b1, cw[i], i == 0);
            end
        end
        rnd_mode  = 1'b0;
        o_ready   = 1'b1;
        idle(DEPTH + 4);

        // Asynchronous reset mid-frame with FIFO non-empty
        o_ready = 1'b0;
        send_frame(ref_encode(4'h9));
        idle(2);
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        rx_bit_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst o_valid", int'(o_valid), 0);
        chk("rst o_data", int'(o_data), 0);
        chk("rst drop_cnt", int'(drop_cnt), 0);
        chk("rst abort_cnt", int'(abort_cnt), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        idle(3);
        @(negedge clk);
        chk("post-rst idle discard", int'(o_valid), 0);
        send_frame(ref_encode(4'h6));
        idle(2);
        @(negedge clk);
        chk("post-rst valid", int'(o_valid), 1);
        chk("post-rst data", int'(o_data), 4'h6);

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ham_serial_rx.md
# ham_serial_rx

Serial receive stage for the Hamming(7,4) link, sitting directly upstream of the codeword decoder and seven-segment error display. It assembles qualified serial bits into 7-bit codewords, computes the syndrome, and corrects single-bit errors. Corrected nibbles are buffered in a small first-word-fall-through FIFO with a valid/ready output. It also keeps saturating link statistics: corrections, framing aborts and overflow drops.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- CNT_W, 8, width of each statistics counter
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rx_bit_valid  in  1  rx_bit/rx_sof qualified this cycle
- rx_bit  in  1  serial codeword bit, codeword bit 0 first
- rx_sof  in  1  marks first bit of a frame; ignored unless rx_bit_valid
- o_ready  in  1  consumer accepts head word
- o_valid  out  1  FIFO non-empty
- o_data  out  4  corrected nibble {d3,d2,d1,d0}
- o_syndrome  out  3  {z4,z2,z1} of the head word
- o_corrected  out  1  head word had nonzero syndrome
- clr_stats  in  1  synchronous clear of all counters
- corr_cnt  out  CNT_W  frames with nonzero syndrome
- abort_cnt  out  CNT_W  frames cut short by rx_sof
- drop_cnt  out  CNT_W  frames lost to FIFO full

## Operation
- Codeword layout, bit6..0: {d3,d2,d1,p4,d0,p2,p1}.
- Syndrome bits:
  - z1 = c0^c2^c4^c6
  - z2 = c1^c2^c5^c6
  - z4 = c3^c4^c5^c6
- Correction by syndrome:
  - 3 flips c2 (d0), 5 flips c4 (d1), 6 flips c5 (d2), 7 flips c6 (d3).
  - 1, 2 and 4 are parity-bit errors; data is unchanged but o_corrected is still 1.
- FSM states are IDLE, SHIFT and CHECK.
- IDLE:
  - A valid bit with rx_sof loads c0, sets bit count to 1, and moves to SHIFT.
  - A valid bit without rx_sof is discarded.
- SHIFT:
  - Each valid bit without rx_sof loads c[count] and increments count.
  - Loading c6 moves to CHECK.
  - rx_bit_valid low holds all state.
  - A valid bit with rx_sof aborts the partial frame (abort_cnt+1), loads the bit as c0, sets count to 1, and stays in SHIFT.
- CHECK (one cycle):
  - Decodes and pushes {data, syndrome, corrected} to the FIFO.
  - corr_cnt+1 if the syndrome is nonzero.
  - Input handling this cycle is identical to IDLE, so a back-to-back rx_sof starts the next frame without losing a bit. Next state is SHIFT if rx_sof was accepted, else IDLE.
- FIFO rules:
  - A push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise the word is dropped and drop_cnt+1.
  - A pop happens when o_valid && o_ready.
  - Read and write pointers are log2(DEPTH)+1 bits and wrap naturally. Full means the MSBs differ and the rest are equal.
- Counters:
  - All counters saturate at 2^CNT_W−1.
  - clr_stats zeroes all counters and takes priority over any same-cycle increment.
- Corrected data is exact for at most one flipped bit. Two-bit errors produce a miscorrected nibble; they are not detected here, and detecting them is the downstream stage's responsibility.

## Timing
- Reset values:
  - FSM in IDLE, count 0.
  - FIFO empty.
  - o_valid 0, o_data/o_syndrome/o_corrected 0.
  - All counters 0.
- Latency: if c6 is accepted on edge E, the word is written on edge E+1. If the FIFO was empty, o_valid rises after E+1; the head word is combinational from the storage array.
- Sustained throughput is one frame per 7 valid bits; CHECK overlaps the next frame's c0.
- o_data, o_syndrome and o_corrected are stable while o_valid && !o_ready.
- Asserting rst_n low mid-frame or with the FIFO non-empty discards everything immediately. This is asynchronous and no counter increments.

## Structure
- Package ham_pkg:
  - CW_W=7 and DATA_W=4.
  - Codeword bit-index constants P1..D3.
  - Typedef ham_word_t {data[3:0], syndrome[2:0], corrected} stored in the FIFO.
  - Function ham_correct(cw) returning a ham_word_t; shared with the encoder bench.
- One sub-module, ham_fifo: parameterised FWFT FIFO holding ham_word_t. Its push/pop/full/empty logic is reused by the transmit side.

## Test plan
- Clean frame: data 4'b1011 sent as codeword 7'b1010101 (bits 1,0,1,0,1,0,1) -> o_data=1011, o_syndrome=0, o_corrected=0, o_valid 2 cycles after the rx_sof bit plus 6.
- Single data error: same frame with c4 flipped (7'b1000101) -> o_data=1011, o_syndrome=3'b101, o_corrected=1, corr_cnt=1.
- Parity error and back-to-back: 4'hF (7'b1111111) with c3 flipped, then immediately 4'h0 (7'b0000000) with rx_sof in the CHECK cycle -> two entries: F with syndrome 4, then 0 with syndrome 0; no bit lost.
- Abort: rx_sof reasserted after 3 bits, followed by a full clean frame of 4'h5 -> abort_cnt=1, a single entry 4'h5.
- Overflow: o_ready=0 with DEPTH+2 frames sent -> DEPTH entries held, drop_cnt=2; then o_ready=1 drains the entries in order.
- Saturation and reset: CNT_W=2 with 5 corrected frames -> corr_cnt=3. clr_stats -> 0. rst_n pulsed mid-frame -> o_valid=0, FSM back in IDLE.
